// File: rtl/dual_fetch_ctrl.sv
// Paired-address read sequencer for the dual-port memory: IDLE -> LOAD -> READ -> RESP.
// Optional macro FETCH_CNT_EN adds an 8-bit wrapping response counter output fetch_count.
module dual_fetch_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int READ_WAIT  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    output logic                  mar_load_a,
    output logic                  mar_load_b,
    output logic [ADDR_WIDTH-1:0] mar_in_a,
    output logic [ADDR_WIDTH-1:0] mar_in_b,
    output logic                  mem_oe_a,
    output logic                  mem_oe_b,
    input  logic [DATA_WIDTH-1:0] mem_dout_a,
    input  logic [DATA_WIDTH-1:0] mem_dout_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data_a,
    output logic [DATA_WIDTH-1:0] rsp_data_b,
    output logic                  rsp_same
`ifdef FETCH_CNT_EN
    ,
    output logic [7:0]            fetch_count
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready is 1 only in IDLE; rsp_valid is 1 only in RESP and holds data until rsp_ready.
    typedef enum logic [1:0] {IDLE, LOAD, READ, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mar_load_q, mar_load_d;
    logic [ADDR_WIDTH-1:0] mar_in_a_q, mar_in_a_d;
    logic [ADDR_WIDTH-1:0] mar_in_b_q, mar_in_b_d;
    logic                  oe_a_q, oe_a_d;
    logic                  oe_b_q, oe_b_d;
    logic [3:0]            wait_q, wait_d;
    logic                  same_q, same_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_a_q, rsp_data_a_d;
    logic [DATA_WIDTH-1:0] rsp_data_b_q, rsp_data_b_d;
    logic                  rsp_same_q, rsp_same_d;
    logic                  rsp_hs;

    assign rsp_hs = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        mar_load_d   = 1'b0;
        mar_in_a_d   = mar_in_a_q;
        mar_in_b_d   = mar_in_b_q;
        oe_a_d       = 1'b0;
        oe_b_d       = 1'b0;
        wait_d       = wait_q;
        same_d       = same_q;
        rsp_valid_d  = 1'b0;
        rsp_data_a_d = rsp_data_a_q;
        rsp_data_b_d = rsp_data_b_q;
        rsp_same_d   = rsp_same_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    state_d     = LOAD;
                    req_ready_d = 1'b0;
                    mar_load_d  = 1'b1;
                    mar_in_a_d  = req_addr_a;
                    mar_in_b_d  = req_addr_b;
                    same_d      = (req_addr_a == req_addr_b);
                end
            end
            LOAD: begin
                state_d = READ;
                wait_d  = WAIT_INIT;
                oe_a_d  = 1'b1;
                oe_b_d  = !same_q;
            end
            READ: begin
                if (wait_q == 4'd0) begin
                    // A same-address fetch reads only port A and mirrors it onto B.
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_a_d = mem_dout_a;
                    rsp_data_b_d = same_q ? mem_dout_a : mem_dout_b;
                    rsp_same_d   = same_q;
                end else begin
                    wait_d = wait_q - 4'd1;
                    oe_a_d = 1'b1;
                    oe_b_d = !same_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            mar_load_q   <= 1'b0;
            mar_in_a_q   <= '0;
            mar_in_b_q   <= '0;
            oe_a_q       <= 1'b0;
            oe_b_q       <= 1'b0;
            wait_q       <= 4'd0;
            same_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
            rsp_same_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mar_load_q   <= mar_load_d;
            mar_in_a_q   <= mar_in_a_d;
            mar_in_b_q   <= mar_in_b_d;
            oe_a_q       <= oe_a_d;
            oe_b_q       <= oe_b_d;
            wait_q       <= wait_d;
            same_q       <= same_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
            rsp_same_q   <= rsp_same_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mar_load_a = mar_load_q;
    assign mar_load_b = mar_load_q;
    assign mar_in_a   = mar_in_a_q;
    assign mar_in_b   = mar_in_b_q;
    assign mem_oe_a   = oe_a_q;
    assign mem_oe_b   = oe_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rsp_data_a_q;
    assign rsp_data_b = rsp_data_b_q;
    assign rsp_same   = rsp_same_q;

`ifdef FETCH_CNT_EN
    logic [7:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (rsp_hs) fetch_count_d = fetch_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_count_q <= 8'd0;
        else        fetch_count_q <= fetch_count_d;
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_dual_fetch_ctrl.sv
// Bench for dual_fetch_ctrl (READ_WAIT=3): timeline reference model plus directed literal checks.
// Builds with or without FETCH_CNT_EN.
module tb_dual_fetch_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RW = 3;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr_a, req_addr_b;
    logic          mar_load_a, mar_load_b;
    logic [AW-1:0] mar_in_a, mar_in_b;
    logic          mem_oe_a, mem_oe_b;
    logic [DW-1:0] mem_dout_a, mem_dout_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data_a, rsp_data_b;
    logic          rsp_same;
`ifdef FETCH_CNT_EN
    logic [7:0]    fetch_count;
`endif

    dual_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .mar_load_a (mar_load_a),
        .mar_load_b (mar_load_b),
        .mar_in_a   (mar_in_a),
        .mar_in_b   (mar_in_b),
        .mem_oe_a   (mem_oe_a),
        .mem_oe_b   (mem_oe_b),
        .mem_dout_a (mem_dout_a),
        .mem_dout_b (mem_dout_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b),
        .rsp_same   (rsp_same)
`ifdef FETCH_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory + MAR datapath model ----------------
    logic [DW-1:0] mem [16];
    logic [AW-1:0] mar_a, mar_b;

    always @(posedge clk) begin
        if (mar_load_a) mar_a <= mar_in_a;
        if (mar_load_b) mar_b <= mar_in_b;
    end

    // A disabled port returns garbage so reading it by mistake is visible.
    assign mem_dout_a = mem_oe_a ? mem[mar_a] : ~mem[mar_a];
    assign mem_dout_b = mem_oe_b ? mem[mar_b] : ~mem[mar_b];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [7:0]    exp_q[$];
    int            cyc, acc_cyc, rel;
    logic [AW-1:0] ta, tb;
    logic [AW-1:0] exp_mar_a, exp_mar_b;
    logic [DW-1:0] last_da, last_db;
    logic          last_same;
    logic [7:0]    exp_cnt;
    logic          busy, e_load, e_oe_a, e_oe_b, e_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cyc       = 0;
            exp_mar_a = '0;
            exp_mar_b = '0;
            last_da   = '0;
            last_db   = '0;
            last_same = 1'b0;
            exp_cnt   = 8'd0;
        end else begin
            cyc++;
            busy    = (exp_q.size() != 0);
            e_load  = 1'b0;
            e_oe_a  = 1'b0;
            e_oe_b  = 1'b0;
            e_valid = 1'b0;
            if (busy) begin
                ta  = exp_q[0][7:4];
                tb  = exp_q[0][3:0];
                rel = cyc - acc_cyc;
                e_load  = (rel == 1);
                e_oe_a  = (rel >= 2) && (rel <= 2 + RW);
                e_oe_b  = e_oe_a && (ta != tb);
                e_valid = (rel >= 3 + RW);
                if (e_valid) begin
                    last_da   = mem[ta];
                    last_db   = mem[tb];
                    last_same = (ta == tb);
                end
            end
            chk("req_ready",  {31'd0, req_ready},  {31'd0, !busy});
            chk("mar_load_a", {31'd0, mar_load_a}, {31'd0, e_load});
            chk("mar_load_b", {31'd0, mar_load_b}, {31'd0, e_load});
            chk("mar_in_a",   {28'd0, mar_in_a},   {28'd0, exp_mar_a});
            chk("mar_in_b",   {28'd0, mar_in_b},   {28'd0, exp_mar_b});
            chk("mem_oe_a",   {31'd0, mem_oe_a},   {31'd0, e_oe_a});
            chk("mem_oe_b",   {31'd0, mem_oe_b},   {31'd0, e_oe_b});
            chk("rsp_valid",  {31'd0, rsp_valid},  {31'd0, e_valid});
            chk("rsp_data_a", {24'd0, rsp_data_a}, {24'd0, last_da});
            chk("rsp_data_b", {24'd0, rsp_data_b}, {24'd0, last_db});
            chk("rsp_same",   {31'd0, rsp_same},   {31'd0, last_same});
`ifdef FETCH_CNT_EN
            chk("fetch_count", {24'd0, fetch_count}, {24'd0, exp_cnt});
`endif
            if (!busy && req_valid) begin
                exp_q.push_back({req_addr_a, req_addr_b});
                acc_cyc   = cyc;
                exp_mar_a = req_addr_a;
                exp_mar_b = req_addr_b;
            end else if (busy && e_valid && rsp_ready) begin
                void'(exp_q.pop_front());
                hs_cnt++;
                exp_cnt = exp_cnt + 8'd1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fetch(input logic [AW-1:0] a, input logic [AW-1:0] b, input int stall,
                         output int lat, output int na, output int nb,
                         output logic [DW-1:0] da, output logic [DW-1:0] db, output logic sm,
                         output logic hv, output logic [DW-1:0] hda);
        int n;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_addr_a = a;
        req_addr_b = b;
        rsp_ready  = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        lat = 0; na = 0; nb = 0;
        @(posedge clk); #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            na += int'(mem_oe_a);
            nb += int'(mem_oe_b);
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        da = rsp_data_a;
        db = rsp_data_b;
        sm = rsp_same;
        // Requests offered while the response is stalled must be ignored.
        repeat (stall) begin
            @(posedge clk); #1;
            req_valid  = 1'b1;
            req_addr_a = 4'($urandom_range(0, 15));
            req_addr_b = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        hv  = rsp_valid;
        hda = rsp_data_a;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    int            lat, na, nb, guard, cnt;
    logic [DW-1:0] da, db, hda;
    logic          sm, hv;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_addr_a = '0; req_addr_b = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[2] = 8'hAA; mem[3] = 8'h55; mem[1] = 8'h11; mem[9] = 8'h99;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_mar_in_a",  {28'd0, mar_in_a},  32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Reset asserted while the fetch is in READ.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr_a = 4'd5; req_addr_b = 4'd6;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!req_ready && cnt < 50);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_read_oe_a", {31'd0, mem_oe_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_ready", {31'd0, req_ready}, 32'd1);
        chk("async_oe_a",      {31'd0, mem_oe_a},  32'd0);
        chk("async_oe_b",      {31'd0, mem_oe_b},  32'd0);
        chk("async_mar_in_a",  {28'd0, mar_in_a},  32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(rsp_valid); end
        chk("no_rsp_after_reset", cnt, 32'd0);

        fetch(4'd2, 4'd3, 0, lat, na, nb, da, db, sm, hv, hda);
        chk("t2_latency", lat, 32'd6);
        chk("t2_data_a", {24'd0, da}, 32'h0000_00AA);
        chk("t2_data_b", {24'd0, db}, 32'h0000_0055);
        chk("t2_same",   {31'd0, sm}, 32'd0);

        fetch(4'd1, 4'd9, 0, lat, na, nb, da, db, sm, hv, hda);
        chk("t3_data_a", {24'd0, da}, 32'h0000_0011);
        chk("t3_data_b", {24'd0, db}, 32'h0000_0099);
        chk("t3_oe_a_cycles", na, 32'd4);
        chk("t3_oe_b_cycles", nb, 32'd4);

        fetch(4'd2, 4'd2, 0, lat, na, nb, da, db, sm, hv, hda);
        chk("t4_oe_b_cycles", nb, 32'd0);
        chk("t4_oe_a_cycles", na, 32'd4);
        chk("t4_data_a", {24'd0, da}, 32'h0000_00AA);
        chk("t4_data_b", {24'd0, db}, 32'h0000_00AA);
        chk("t4_same",   {31'd0, sm}, 32'd1);

        fetch(4'd3, 4'd1, 5, lat, na, nb, da, db, sm, hv, hda);
        chk("t5_held_valid",  {31'd0, hv},  32'd1);
        chk("t5_held_data_a", {24'd0, hda}, 32'h0000_0055);
        chk("t5_data_b",      {24'd0, db},  32'h0000_0011);

        // Random traffic, long enough to wrap the fetch counter.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        guard = 0;
        while (hs_cnt < 300 && guard < 8000) begin
            @(posedge clk); #1;
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr_a = 4'($urandom_range(0, 15));
            req_addr_b = ($urandom_range(0, 3) == 0) ? req_addr_a : 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            guard++;
        end
        if (hs_cnt < 300) chk("random_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
